// File: rtl/imem_controller_pkg.sv
// Shared constants, FSM encoding and address helper for the instruction-RAM controller.
package imem_controller_pkg;
  localparam int IMC_ADDRESS_BUS_WIDTH = 10;
  localparam int IMC_INSTRUCTION_WIDTH = 19;
  localparam int IMC_STARVE_LIMIT      = 4;

  typedef enum logic {
    IMC_IDLE  = 1'b0,
    IMC_RDATA = 1'b1
  } imc_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction
endpackage

// File: rtl/imem_starve_counter.sv
// Saturating count of consecutive loader wins while a fetch is waiting.
module imem_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_controller.sv
// Arbitrates the single-port instruction RAM between fetch reads and loader writes,
// and turns the RAM's registered read into a one-cycle fetch response.
module imem_controller
  import imem_controller_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = IMC_ADDRESS_BUS_WIDTH,
  parameter int INSTRUCTION_WIDTH = IMC_INSTRUCTION_WIDTH,
  parameter int STARVE_LIMIT      = IMC_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fetch_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr,
  output logic                         fetch_gnt,
  output logic                         fetch_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_rdata,
  output logic                         fetch_err,
  input  logic                         load_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] load_wdata,
  output logic                         load_gnt,
  output logic                         load_err,
  output logic [ADDRESS_BUS_WIDTH-1:0] ram_addr,
  output logic                         ram_read,
  output logic                         ram_write,
  output logic [INSTRUCTION_WIDTH-1:0] ram_wdata,
  input  logic [INSTRUCTION_WIDTH-1:0] ram_rdata,
  output logic                         busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  imc_state_e       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             load_win, fetch_win;

  imem_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (load_gnt & fetch_req),
    .clr     (fetch_gnt | ~fetch_req),
    .cnt     (starve_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IMC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The loader yields only once it has starved a waiting fetch STARVE_LIMIT times.
  assign load_win  = load_req && (!fetch_req || (starve_cnt < CNT_W'(STARVE_LIMIT)));
  assign fetch_win = !load_win && fetch_req;

  always_comb begin
    state_nxt    = state;
    fetch_gnt    = 1'b0;
    fetch_err    = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    load_gnt     = 1'b0;
    load_err     = 1'b0;
    ram_addr     = '0;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    ram_wdata    = '0;
    busy         = 1'b0;
    case (state)
      IMC_IDLE: begin
        if (load_win) begin
          load_gnt = 1'b1;
          if (is_word_aligned(load_addr[1:0])) begin
            ram_write = 1'b1;
            ram_addr  = load_addr;
            ram_wdata = load_wdata;
          end else begin
            load_err = 1'b1;
          end
        end else if (fetch_win) begin
          fetch_gnt = 1'b1;
          if (is_word_aligned(fetch_addr[1:0])) begin
            ram_read  = 1'b1;
            ram_addr  = fetch_addr;
            state_nxt = IMC_RDATA;
          end else begin
            fetch_err = 1'b1;
          end
        end
      end
      IMC_RDATA: begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = ram_rdata;
        busy         = 1'b1;
        state_nxt    = IMC_IDLE;
      end
      default: state_nxt = IMC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_controller.sv
// Self-checking bench: directed scenarios plus randomized requesters against a behavioural model.
module tb_imem_controller;
  localparam int AW = 10;
  localparam int IW = 19;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [IW-1:0] fetch_rdata;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_wdata = '0;
  logic          load_gnt, load_err;
  logic [AW-1:0] ram_addr;
  logic          ram_read, ram_write;
  logic [IW-1:0] ram_wdata;
  logic [IW-1:0] ram_rdata = '0;
  logic          busy;

  imem_controller #(
    .ADDRESS_BUS_WIDTH (AW),
    .INSTRUCTION_WIDTH (IW),
    .STARVE_LIMIT      (LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_err(load_err),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple registered-read RAM standing in for instruction_ram.
  logic [IW-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr[9:2]] <= ram_wdata;
    if (ram_read)  ram_rdata <= ram_mem[ram_addr[9:2]];
  end

  // Behavioural model state
  logic [IW-1:0] mdl_mem [0:255];
  bit            m_pend;
  logic [IW-1:0] m_data;
  int            m_starve;

  int total = 0;
  int bad = 0;

  // Outputs sampled in the last step
  logic          s_fg, s_lg, s_busy;
  int            s_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
  task automatic step(input logic fr, input logic [AW-1:0] fa, input logic lr,
                      input logic [AW-1:0] la, input logic [IW-1:0] lwd);
    bit lw, fw, fal, lal;
    logic [7:0] exp_flags, act_flags;
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la; load_wdata = lwd;
    @(negedge clk);
    lw  = !m_pend && lr && (!fr || m_starve < LIMIT);
    fw  = !m_pend && !lw && fr;
    fal = (fa % 4) == 0;
    lal = (la % 4) == 0;
    exp_flags = {fw, fw && !fal, lw, lw && !lal, fw && fal, lw && lal, m_pend, m_pend};
    act_flags = {fetch_gnt, fetch_err, load_gnt, load_err, ram_read, ram_write, busy, fetch_rvalid};
    chk("flags", {24'd0, act_flags}, {24'd0, exp_flags});
    if (fw && fal) chk("rd_addr", {22'd0, ram_addr}, {22'd0, fa});
    if (lw && lal) begin
      chk("wr_addr", {22'd0, ram_addr}, {22'd0, la});
      chk("wr_data", {13'd0, ram_wdata}, {13'd0, lwd});
    end
    if (m_pend) chk("rdata", {13'd0, fetch_rdata}, {13'd0, m_data});
    s_fg = fetch_gnt; s_lg = load_gnt; s_busy = busy;
    s_code = load_gnt ? 1 : fetch_gnt ? 2 : busy ? 3 : 0;
    @(posedge clk);
    if (m_pend) begin
      m_pend = 1'b0;
    end else if (lw) begin
      if (lal) mdl_mem[la / 4] = lwd;
      m_starve = fr ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
    end else if (fw) begin
      m_starve = 0;
      if (fal) begin
        m_pend = 1'b1;
        m_data = mdl_mem[fa / 4];
      end
    end
    if (!fr) m_starve = 0;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Both requesters held high: four loads, a fetch, its response cycle, repeating.
  task automatic starve_pattern(input string nm);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 10'h100, 1'b1, 10'h104, 19'(i));
      chk(nm, s_code, (i % 6 < 4) ? 1 : (i % 6 == 4) ? 2 : 3);
    end
  endtask

  bit            fr_h, lr_h;
  logic [AW-1:0] fa_c, la_c;
  logic [IW-1:0] lwd_c;

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 19'($urandom);
      mdl_mem[i] = ram_mem[i];
    end
    ram_mem[128] = 19'h20100;
    mdl_mem[128] = 19'h20100;
    m_pend = 1'b0; m_data = '0; m_starve = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_flags", {24'd0, fetch_gnt, fetch_err, load_gnt, load_err, ram_read, ram_write, busy, fetch_rvalid}, 32'd0);
    chk("reset_bus", {3'd0, ram_addr, ram_wdata}, 32'd0);
    chk("reset_rdata", {13'd0, fetch_rdata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    step(1'b1, 10'h200, 1'b0, '0, '0);
    chk("fetch_gnt", {31'd0, s_fg}, 32'd1);
    idle_step();
    chk("fetch_resp", {31'd0, s_busy}, 32'd1);
    chk("fetch_word", {13'd0, m_data}, 32'h20100);

    // Write then readback
    step(1'b0, '0, 1'b1, 10'h214, 19'h34BFD);
    chk("load_gnt", {31'd0, s_lg}, 32'd1);
    idle_step();
    step(1'b1, 10'h214, 1'b0, '0, '0);
    idle_step();
    chk("readback", {13'd0, m_data}, 32'h34BFD);

    // Starvation limit
    starve_pattern("starve");
    idle_step();

    // Misaligned fetch
    step(1'b1, 10'h202, 1'b0, '0, '0);
    chk("misalign_gnt", {31'd0, s_fg}, 32'd1);
    idle_step();
    chk("misalign_norv", {31'd0, s_busy}, 32'd0);

    // Back-to-back fetches
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 10'(i * 4), 1'b0, '0, '0);
      chk("b2b", s_code, (i % 2 == 0) ? 2 : 3);
    end
    idle_step();

    // Reset mid-read
    step(1'b1, 10'h040, 1'b0, '0, '0);
    fetch_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    m_pend = 1'b0; m_starve = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    starve_pattern("post_rst");
    idle_step();

    // Randomized requesters
    fr_h = 0; lr_h = 0; fa_c = '0; la_c = '0; lwd_c = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!fr_h && $urandom_range(0, 2) == 0) begin fr_h = 1; fa_c = rand_addr(); end
      else if (fr_h && $urandom_range(0, 19) == 0) fr_h = 0;
      if (!lr_h && $urandom_range(0, 2) == 0) begin
        lr_h = 1; la_c = rand_addr(); lwd_c = 19'($urandom);
      end else if (lr_h && $urandom_range(0, 19) == 0) lr_h = 0;
      step(fr_h, fa_c, lr_h, la_c, lwd_c);
      if (s_fg) fr_h = 0;
      if (s_lg) lr_h = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
